// File: rtl/pokey_key_scanner_if.sv
// Keyboard scanner bus: SKCTL enable, matrix return lines, IRQST clear,
// and the scan/keycode/status outputs consumed by the POKEY register logic.
//   master : drives scan_en, kr1_L, kr2_L, irq_clr; observes scanner outputs
//   slave  : the scanner itself
interface pokey_key_scanner_if #(
  parameter int unsigned KEY_BITS = 6
);
  logic                scan_en;
  logic                kr1_L;
  logic                kr2_L;
  logic                irq_clr;
  logic [KEY_BITS-1:0] key_scan_L;
  logic [KEY_BITS-1:0] keycode;
  logic                shift;
  logic                key_depr;
  logic                key_irq;
  logic                overrun;

  modport master (
    output scan_en, kr1_L, kr2_L, irq_clr,
    input  key_scan_L, keycode, shift, key_depr, key_irq, overrun
  );

  modport slave (
    input  scan_en, kr1_L, kr2_L, irq_clr,
    output key_scan_L, keycode, shift, key_depr, key_irq, overrun
  );
endinterface

// File: rtl/pokey_key_scanner.sv
// POKEY keyboard matrix scanner: free-running slot scan, two-visit
// debounce FSM, keycode/shift latch, key-depressed status and a sticky
// key interrupt with overrun detection.
// Ports:
//   o2   - phase-2 clock, all logic on rising edge
//   rst  - synchronous active-high reset
//   bus  - pokey_key_scanner_if.slave (scan_en, kr1_L, kr2_L, irq_clr in;
//          key_scan_L, keycode, shift, key_depr, key_irq, overrun out)
// Optional: define KEY_REPEAT_EN to enable auto-repeat while a key is held
// (first repeat after REPEAT_DELAY visits, then every REPEAT_RATE visits;
// requires 1 <= REPEAT_RATE <= REPEAT_DELAY).
module pokey_key_scanner #(
  parameter int unsigned KEY_BITS     = 6,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned SHIFT_SLOT   = 0,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic                  o2,
  input  logic                  rst,
  pokey_key_scanner_if.slave    bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Elaboration-time parameter sanity check
  if (SCAN_DIV < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
    $error("pokey_key_scanner: illegal SCAN_DIV/REPEAT_RATE/REPEAT_DELAY");
  end

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div, div_nxt;
  logic [KEY_BITS-1:0] scan_cnt, scan_nxt;
  logic [KEY_BITS-1:0] cand, cand_nxt;
  logic [KEY_BITS-1:0] key_scan_q, keycode_q;
  logic                shift_smp, shift_q, key_depr_q, key_irq_q, overrun_q;
  logic                tick, at_cand, latch, depr_nxt;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0]    rpt_cnt, rpt_nxt;
`endif

  // Slot timing: tick closes each slot; scan is frozen at slot 0 while disabled
  assign tick    = bus.scan_en && (div == DIV_W'(SCAN_DIV - 1));
  assign at_cand = (scan_cnt == cand);
  assign div_nxt  = (!bus.scan_en || tick) ? '0 : div + DIV_W'(1);
  assign scan_nxt = !bus.scan_en ? '0 : (tick ? scan_cnt + KEY_BITS'(1) : scan_cnt);

  // Debounce FSM: a key must read pressed on two consecutive visits to its slot
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    depr_nxt  = key_depr_q;
    latch     = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_nxt   = rpt_cnt;
`endif
    if (!bus.scan_en) begin
      state_nxt = IDLE;
      depr_nxt  = 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!bus.kr1_L) begin
            cand_nxt  = scan_cnt;
            state_nxt = CONFIRM;
          end
        end
        CONFIRM: begin
          if (at_cand) begin
            if (!bus.kr1_L) begin
              latch     = 1'b1;
              depr_nxt  = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        HELD: begin
          // Other slots are ignored: the first key wins until released
          if (at_cand) begin
            if (bus.kr1_L) begin
              state_nxt = RELEASE;
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
              latch   = 1'b1;
              // Reload so the next repeat lands REPEAT_RATE visits later
              rpt_nxt = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              rpt_nxt = rpt_cnt + RPT_W'(1);
            end
`endif
          end
        end
        RELEASE: begin
          if (at_cand) begin
            if (bus.kr1_L) begin
              depr_nxt  = 1'b0;
              state_nxt = IDLE;
            end else begin
              state_nxt = HELD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
`ifdef KEY_REPEAT_EN
    if (state_nxt != HELD) rpt_nxt = '0;
`endif
  end

  // State and datapath registers
  always_ff @(posedge o2) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      scan_cnt   <= '0;
      cand       <= '0;
      key_scan_q <= '1;
      shift_smp  <= 1'b0;
      keycode_q  <= '0;
      shift_q    <= 1'b0;
      key_depr_q <= 1'b0;
      key_irq_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      scan_cnt   <= scan_nxt;
      cand       <= cand_nxt;
      key_scan_q <= ~scan_nxt;
      key_depr_q <= depr_nxt;
`ifdef KEY_REPEAT_EN
      rpt_cnt    <= rpt_nxt;
`endif
      if (tick && scan_cnt == KEY_BITS'(SHIFT_SLOT)) shift_smp <= ~bus.kr2_L;
      if (latch) begin
        keycode_q <= cand;
        shift_q   <= shift_smp;
      end
      // A latch in the same cycle as irq_clr takes priority
      if (latch) begin
        key_irq_q <= 1'b1;
        if (key_irq_q) overrun_q <= 1'b1;
      end else if (bus.irq_clr) begin
        key_irq_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.key_scan_L = key_scan_q;
  assign bus.keycode    = keycode_q;
  assign bus.shift      = shift_q;
  assign bus.key_depr   = key_depr_q;
  assign bus.key_irq    = key_irq_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pokey_key_scanner.sv
// Directed bench for pokey_key_scanner (KEY_BITS=4, SCAN_DIV=2 instance plus
// a default-parameter instance). A behavioural key matrix pulls kr1_L/kr2_L
// low while the scan lines address the pressed key / shift slot.
// Edge numbers below count rising edges after reset release; slot s is
// evaluated on edge 2*(s+1) + 32*n.
module tb_pokey_key_scanner;
  localparam int unsigned KB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pokey_key_scanner_if #(.KEY_BITS(KB)) bus ();
  pokey_key_scanner #(
    .KEY_BITS(KB), .SCAN_DIV(2), .SHIFT_SLOT(0), .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (.o2(clk), .rst(rst), .bus(bus));

  pokey_key_scanner_if #(.KEY_BITS(6)) dbus ();
  pokey_key_scanner u_dflt (.o2(clk), .rst(rst), .bus(dbus));
  assign dbus.scan_en = 1'b1;
  assign dbus.kr1_L   = 1'b1;
  assign dbus.kr2_L   = 1'b1;
  assign dbus.irq_clr = 1'b0;

  logic          key_on, shift_on;
  logic [KB-1:0] key_sel;
  int            edge_n;
  int            vectors = 0;
  int            errors  = 0;

  // Key matrix model
  always_comb begin
    bus.kr1_L = !(key_on && ((~bus.key_scan_L) == key_sel));
    bus.kr2_L = !(shift_on && ((~bus.key_scan_L) == KB'(0)));
  end

  task automatic do_reset();
    rst = 1'b1; key_on = 1'b0; shift_on = 1'b0; key_sel = '0;
    bus.irq_clr = 1'b0; bus.scan_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.key_scan_L !== 4'hF) begin errors++; $display("FAIL rst_scan: got %h want %h", bus.key_scan_L, 4'hF); end
    vectors++; if (bus.keycode !== 4'h0) begin errors++; $display("FAIL rst_keycode: got %h want %h", bus.keycode, 4'h0); end
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL rst_depr: got %b want 0", bus.key_depr); end
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", bus.key_irq); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
    vectors++; if (bus.shift !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b want 0", bus.shift); end
    vectors++; if (dbus.key_scan_L !== 6'h3F) begin errors++; $display("FAIL rst_dflt_scan: got %h want %h", dbus.key_scan_L, 6'h3F); end
    step_to(2);
    vectors++; if (bus.key_scan_L !== 4'hE) begin errors++; $display("FAIL scan_slot1: got %h want %h", bus.key_scan_L, 4'hE); end
    step_to(3);
    vectors++; if (dbus.key_scan_L !== 6'h3F) begin errors++; $display("FAIL dflt_div_hold: got %h want %h", dbus.key_scan_L, 6'h3F); end
    step_to(4);
    vectors++; if (dbus.key_scan_L !== 6'h3E) begin errors++; $display("FAIL dflt_div_tick: got %h want %h", dbus.key_scan_L, 6'h3E); end
  endtask

  task automatic test_press_latency();
    do_reset();
    key_sel = 4'd9; key_on = 1'b1;
    step_to(51);
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL lat_early_depr: got %b want 0", bus.key_depr); end
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL lat_early_irq: got %b want 0", bus.key_irq); end
    step_to(52);
    vectors++; if (bus.key_depr !== 1'b1) begin errors++; $display("FAIL lat_depr: got %b want 1", bus.key_depr); end
    vectors++; if (bus.keycode !== 4'd9) begin errors++; $display("FAIL lat_keycode: got %0d want 9", bus.keycode); end
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL lat_irq: got %b want 1", bus.key_irq); end
    vectors++; if (bus.shift !== 1'b0) begin errors++; $display("FAIL lat_shift: got %b want 0", bus.shift); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL lat_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_shift_release();
    do_reset();
    key_sel = 4'd9; key_on = 1'b1; shift_on = 1'b1;
    step_to(52);
    vectors++; if (bus.shift !== 1'b1) begin errors++; $display("FAIL sh_shift: got %b want 1", bus.shift); end
    vectors++; if (bus.keycode !== 4'd9) begin errors++; $display("FAIL sh_keycode: got %0d want 9", bus.keycode); end
    key_on = 1'b0; shift_on = 1'b0;
    step_to(115);
    vectors++; if (bus.key_depr !== 1'b1) begin errors++; $display("FAIL rel_early_depr: got %b want 1", bus.key_depr); end
    step_to(116);
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL rel_depr: got %b want 0", bus.key_depr); end
    vectors++; if (bus.keycode !== 4'd9) begin errors++; $display("FAIL rel_keycode: got %0d want 9", bus.keycode); end
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL rel_irq_sticky: got %b want 1", bus.key_irq); end
  endtask

  task automatic test_glitch();
    do_reset();
    key_sel = 4'd5;
    step_to(11); key_on = 1'b1;
    step_to(12); key_on = 1'b0;
    step_to(46);
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL gl_irq: got %b want 0", bus.key_irq); end
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL gl_depr: got %b want 0", bus.key_depr); end
    // A later press of another key must still be accepted (FSM back in IDLE)
    step_to(80); key_sel = 4'd6; key_on = 1'b1;
    step_to(141);
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL gl_k6_early: got %b want 0", bus.key_irq); end
    step_to(142);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL gl_k6_irq: got %b want 1", bus.key_irq); end
    vectors++; if (bus.keycode !== 4'd6) begin errors++; $display("FAIL gl_k6_code: got %0d want 6", bus.keycode); end
  endtask

  task automatic test_overrun();
    do_reset();
    key_sel = 4'd3; key_on = 1'b1;
    step_to(40);
    vectors++; if (bus.keycode !== 4'd3) begin errors++; $display("FAIL ov_k3_code: got %0d want 3", bus.keycode); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ov_k3_overrun: got %b want 0", bus.overrun); end
    key_on = 1'b0;
    step_to(104); key_sel = 4'd7; key_on = 1'b1;
    step_to(144);
    vectors++; if (bus.keycode !== 4'd7) begin errors++; $display("FAIL ov_k7_code: got %0d want 7", bus.keycode); end
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL ov_k7_irq: got %b want 1", bus.key_irq); end
    vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ov_set: got %b want 1", bus.overrun); end
    bus.irq_clr = 1'b1; key_on = 1'b0;
    step_to(145); bus.irq_clr = 1'b0;
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b want 0", bus.key_irq); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun: got %b want 0", bus.overrun); end
    step_to(208);
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL ov_k7_released: got %b want 0", bus.key_depr); end
    key_on = 1'b1;
    step_to(271); bus.irq_clr = 1'b1;
    step_to(272); bus.irq_clr = 1'b0;
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL coinc_irq: got %b want 1", bus.key_irq); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_scan_en();
    do_reset();
    key_sel = 4'd2; key_on = 1'b1;
    step_to(38);
    vectors++; if (bus.key_depr !== 1'b1) begin errors++; $display("FAIL en_latch_depr: got %b want 1", bus.key_depr); end
    bus.scan_en = 1'b0;
    step_to(39);
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL en_off_depr: got %b want 0", bus.key_depr); end
    vectors++; if (bus.key_scan_L !== 4'hF) begin errors++; $display("FAIL en_off_scan: got %h want %h", bus.key_scan_L, 4'hF); end
    vectors++; if (bus.keycode !== 4'd2) begin errors++; $display("FAIL en_off_keycode: got %0d want 2", bus.keycode); end
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL en_off_irq: got %b want 1", bus.key_irq); end
    step_to(45); bus.scan_en = 1'b1;
    step_to(46);
    vectors++; if (bus.key_scan_L !== 4'hF) begin errors++; $display("FAIL en_on_slot0: got %h want %h", bus.key_scan_L, 4'hF); end
    step_to(47);
    vectors++; if (bus.key_scan_L !== 4'hE) begin errors++; $display("FAIL en_on_slot1: got %h want %h", bus.key_scan_L, 4'hE); end
    step_to(82);
    vectors++; if (bus.key_depr !== 1'b0) begin errors++; $display("FAIL en_relatch_early: got %b want 0", bus.key_depr); end
    step_to(83);
    vectors++; if (bus.key_depr !== 1'b1) begin errors++; $display("FAIL en_relatch_depr: got %b want 1", bus.key_depr); end
    vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL en_relatch_overrun: got %b want 1", bus.overrun); end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    do_reset();
    key_sel = 4'd2; key_on = 1'b1;
    step_to(38);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL rpt_v0_irq: got %b want 1", bus.key_irq); end
    bus.irq_clr = 1'b1; step_to(39); bus.irq_clr = 1'b0;
    step_to(70);
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL rpt_v1_quiet: got %b want 0", bus.key_irq); end
    step_to(101);
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL rpt_v2_early: got %b want 0", bus.key_irq); end
    step_to(102);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL rpt_v2_irq: got %b want 1", bus.key_irq); end
    bus.irq_clr = 1'b1; step_to(103); bus.irq_clr = 1'b0;
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL rpt_v2_clr: got %b want 0", bus.key_irq); end
    step_to(134);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL rpt_v3_irq: got %b want 1", bus.key_irq); end
    bus.irq_clr = 1'b1; step_to(135); bus.irq_clr = 1'b0;
    step_to(166);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL rpt_v4_irq: got %b want 1", bus.key_irq); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rpt_overrun: got %b want 0", bus.overrun); end
    vectors++; if (bus.keycode !== 4'd2) begin errors++; $display("FAIL rpt_keycode: got %0d want 2", bus.keycode); end
  endtask
`else
  task automatic test_no_repeat();
    do_reset();
    key_sel = 4'd2; key_on = 1'b1;
    step_to(38);
    vectors++; if (bus.key_irq !== 1'b1) begin errors++; $display("FAIL norpt_irq: got %b want 1", bus.key_irq); end
    bus.irq_clr = 1'b1; step_to(39); bus.irq_clr = 1'b0;
    step_to(200);
    vectors++; if (bus.key_irq !== 1'b0) begin errors++; $display("FAIL norpt_quiet: got %b want 0", bus.key_irq); end
    vectors++; if (bus.key_depr !== 1'b1) begin errors++; $display("FAIL norpt_depr: got %b want 1", bus.key_depr); end
  endtask
`endif

  initial begin
    test_reset();
    test_press_latency();
    test_shift_release();
    test_glitch();
    test_overrun();
    test_scan_en();
`ifdef KEY_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
